// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ byte sources.
// Ports:
//   clk, reset_n              clock and asynchronous active-low reset
//   req_valid/req_data        per-requester byte offer (byte i at [8i+7:8i])
//   req_ready                 one-cycle one-hot accept pulse
//   uart_data/load/start      transmitter data, load strobe and start request
//   uart_finish               transmitter idle/done flag
//   clear_err                 synchronous clear of timeout_err
//   busy, grant_id            activity flag and last granted requester
//   timeout_err               sticky flag: start was never acknowledged
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GRANT_W     = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_data,
  output logic                   uart_load,
  output logic                   uart_start,
  input  logic                   uart_finish,
  input  logic                   clear_err,
  output logic                   busy,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   timeout_err
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, GAP} state_t;
  state_t               r_state, w_next;
  logic [15:0]          r_cnt, w_cnt;
  logic [GRANT_W-1:0]   r_ptr, w_ptr, w_win, w_grant;
  logic [NUM_REQ-1:0]   w_ready;
  logic [7:0]           w_data, w_byte;
  logic                 w_found, w_load, w_start, w_err, w_gap_done, w_ack_expired;
  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win = GRANT_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign w_byte = req_data[8*int'(w_win) +: 8];
  // GAP_CYCLES of zero still spends a single cycle in GAP.
  assign w_gap_done = (GAP_CYCLES == 0) || (r_cnt >= 16'(GAP_CYCLES - 1));
  assign w_ack_expired = (r_cnt == 16'(ACK_TIMEOUT));
  always_comb begin
    w_next = r_state;
    w_cnt = '0;
    w_ptr = r_ptr;
    w_ready = '0;
    w_data = uart_data;
    w_load = 1'b0;
    w_start = 1'b0;
    w_grant = grant_id;
    w_err = timeout_err & ~clear_err;
    case (r_state)
      IDLE: begin
        if (uart_finish && w_found) begin
          w_ready = NUM_REQ'(1) << w_win;
          w_data = w_byte;
          w_grant = w_win;
          w_ptr = w_win;
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        w_next = START;
      end
      // The first START cycle only counts; uart_start rises one cycle after uart_load.
      START: begin
        if (!uart_finish) w_next = WAIT_DONE;
        else if (w_ack_expired) begin
          w_err = 1'b1;
          w_next = GAP;
        end else begin
          w_start = 1'b1;
          w_cnt = r_cnt + 16'd1;
        end
      end
      WAIT_DONE: w_next = uart_finish ? GAP : WAIT_DONE;
      GAP: begin
        w_next = w_gap_done ? IDLE : GAP;
        w_cnt = w_gap_done ? '0 : r_cnt + 16'd1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ptr <= GRANT_W'(NUM_REQ - 1);
      req_ready <= '0;
      uart_data <= '0;
      uart_load <= 1'b0;
      uart_start <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_ptr <= w_ptr;
      req_ready <= w_ready;
      uart_data <= w_data;
      uart_load <= w_load;
      uart_start <= w_start;
      busy <= (w_next != IDLE);
      grant_id <= w_grant;
      timeout_err <= w_err;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_load, uart_start, busy, timeout_err;
  logic        uart_finish = 1'b1;
  logic        clear_err = 1'b0;
  logic [1:0]  grant_id;
  int n_checks = 0;
  int n_pass = 0;
  uart_tx_arbiter #(.NUM_REQ(4), .GRANT_W(2), .GAP_CYCLES(2), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_data(uart_data), .uart_load(uart_load),
    .uart_start(uart_start), .uart_finish(uart_finish), .clear_err(clear_err),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    uart_finish = 1'b1;
    clear_err = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask
  task automatic serve(input int exp_id, input logic [7:0] exp_byte, input logic [3:0] next_valid);
    logic [3:0] exp_ready;
    exp_ready = 4'b0001 << exp_id;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (req_ready != 0) break;
    end
    n_checks++; if (req_ready !== exp_ready) $display("FAIL serve_ready got %b exp %b", req_ready, exp_ready); else n_pass++;
    n_checks++; if (grant_id !== 2'(exp_id)) $display("FAIL serve_grant_id got %0d exp %0d", grant_id, exp_id); else n_pass++;
    req_valid = next_valid;
    tick();
    n_checks++; if ({req_ready, uart_load, uart_data} !== {4'b0000, 1'b1, exp_byte})
      $display("FAIL serve_load got ready=%b load=%b data=%h exp ready=0000 load=1 data=%h", req_ready, uart_load, uart_data, exp_byte); else n_pass++;
    tick();
    n_checks++; if ({uart_start, uart_load} !== 2'b10) $display("FAIL serve_start got start=%b load=%b exp 1 0", uart_start, uart_load); else n_pass++;
    uart_finish = 1'b0;
    tick();
    uart_finish = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++; if ({req_ready, uart_data, uart_load, uart_start, busy, grant_id, timeout_err} !== 17'd0)
      $display("FAIL reset_outputs got ready=%b data=%h load=%b start=%b busy=%b gid=%0d err=%b exp all 0",
               req_ready, uart_data, uart_load, uart_start, busy, grant_id, timeout_err); else n_pass++;
  endtask
  task automatic test_single();
    int s;
    logic [2:0] b;
    logic bad;
    do_reset();
    req_data = 32'h00A5_0000;
    req_valid = 4'b0100;
    tick();
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL single_ready got %b exp 0100", req_ready); else n_pass++;
    n_checks++; if ({busy, grant_id} !== 3'b110) $display("FAIL single_busy_gid got busy=%b gid=%0d exp 1 2", busy, grant_id); else n_pass++;
    req_valid = '0;
    tick();
    n_checks++; if ({uart_load, uart_start, uart_data} !== {2'b10, 8'hA5}) $display("FAIL single_load got load=%b start=%b data=%h exp 1 0 a5", uart_load, uart_start, uart_data); else n_pass++;
    s = 0;
    repeat (3) begin
      tick();
      s += int'(uart_start);
    end
    uart_finish = 1'b0;
    tick();
    n_checks++; if (s != 3 || uart_start !== 1'b0) $display("FAIL single_start_len got %0d then %b exp 3 then 0", s, uart_start); else n_pass++;
    bad = 1'b0;
    repeat (99) begin
      tick();
      bad |= uart_start | ~busy;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL single_wait_done got bad=%b exp 0", bad); else n_pass++;
    uart_finish = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      b[2-k] = busy;
    end
    n_checks++; if (b !== 3'b110) $display("FAIL single_gap_busy got %b exp 110", b); else n_pass++;
  endtask
  task automatic test_round_robin();
    do_reset();
    req_data = 32'h1312_1110;
    req_valid = 4'b1111;
    serve(0, 8'h10, 4'b1111);
    serve(1, 8'h11, 4'b1111);
    serve(2, 8'h12, 4'b1111);
    serve(3, 8'h13, 4'b1111);
    serve(0, 8'h10, 4'b0000);
  endtask
  task automatic test_fairness_skip();
    do_reset();
    req_data = 32'h5A6B_7C8D;
    req_valid = 4'b0010;
    serve(1, 8'h7C, 4'b0000);
    req_valid = 4'b1001;
    serve(3, 8'h5A, 4'b0001);
    serve(0, 8'h8D, 4'b0000);
  endtask
  task automatic test_timeout();
    int n;
    do_reset();
    req_data = 32'h4433_2211;
    req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (req_ready != 0) break;
    end
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL timeout_ready got %b exp 0001", req_ready); else n_pass++;
    req_valid = '0;
    tick();
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (uart_start) n++;
      else if (n > 0) break;
    end
    n_checks++; if (n != 8) $display("FAIL timeout_start_len got %0d exp 8", n); else n_pass++;
    n_checks++; if ({timeout_err, grant_id} !== 3'b100) $display("FAIL timeout_err_set got err=%b gid=%0d exp 1 0", timeout_err, grant_id); else n_pass++;
    req_valid = 4'b0010;
    serve(1, 8'h22, 4'b0000);
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_err_sticky got %b exp 1", timeout_err); else n_pass++;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL timeout_err_clear got %b exp 0", timeout_err); else n_pass++;
  endtask
  task automatic test_blocked();
    logic seen;
    do_reset();
    req_data = 32'h0000_00C3;
    uart_finish = 1'b0;
    req_valid = 4'b0001;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= |req_ready | busy;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL blocked_no_grant got %b exp 0", seen); else n_pass++;
    uart_finish = 1'b1;
    tick();
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL blocked_release got %b exp 0001", req_ready); else n_pass++;
    req_valid = '0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    req_data = 32'hD4C3_B2A1;
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (req_ready != 0) break;
    end
    req_valid = '0;
    tick();
    tick();
    uart_finish = 1'b0;
    tick();
    tick();
    n_checks++; if ({busy, uart_start, grant_id} !== 4'b1001) $display("FAIL midrst_wait_done got busy=%b start=%b gid=%0d exp 1 0 1", busy, uart_start, grant_id); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({req_ready, uart_data, uart_load, uart_start, busy, grant_id, timeout_err} !== 17'd0)
      $display("FAIL midrst_async got ready=%b data=%h load=%b start=%b busy=%b gid=%0d err=%b exp all 0",
               req_ready, uart_data, uart_load, uart_start, busy, grant_id, timeout_err); else n_pass++;
    tick();
    reset_n = 1'b1;
    uart_finish = 1'b1;
    req_valid = 4'b1001;
    serve(0, 8'hA1, 4'b0000);
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness_skip();
    test_timeout();
    test_blocked();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
